// File: rtl/sprite_dma_if.sv
// Sprite DMA bus bundle: video-timing/CPU request inputs, source bus and
// sprite-attribute RAM write port. master = DMA engine, slave = system side.
interface sprite_dma_if;
  logic        vblk;
  logic        start;
  logic [15:0] srcbase;
  logic        breq;
  logic        bgnt;
  logic [15:0] srcad;
  logic [7:0]  srcrd;
  logic        sawe;
  logic [8:0]  saad;
  logic [7:0]  sawd;
  logic        sprb;
  logic        busy;
  logic        done;

  modport master (
    input  vblk, start, srcbase, bgnt, srcrd,
    output breq, srcad, sawe, saad, sawd, sprb, busy, done
  );

  modport slave (
    output vblk, start, srcbase, bgnt, srcrd,
    input  breq, srcad, sawe, saad, sawd, sprb, busy, done
  );
endinterface

// File: rtl/sprite_dma.sv
// Vertical-blank sprite table copier: reads 4*SPRITES bytes from CPU space
// into the back bank of the sprite-attribute RAM, then flips the display bank.
module sprite_dma #(
  parameter int SPRITES = 48,
  parameter int SRCLAT  = 1
) (
  input  logic          i_vclk,
  input  logic          i_resetn,
  sprite_dma_if.master  io_bus
);

  localparam int unsigned NB     = 4 * SPRITES;
  localparam logic [8:0]  NB_C   = 9'(NB);
  localparam logic [8:0]  LAST_C = 9'(NB - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_FLIP} state_t;

  state_t      r_state;
  logic        r_pend, r_vblk_d, r_sprb, r_breq, r_busy, r_done, r_sawe;
  logic [15:0] r_base, r_srcad;
  logic [8:0]  r_icnt, r_wcnt, r_saad;
  logic [7:0]  r_sawd;
  // Issue-to-write valid shift register plus the byte index riding with it.
  logic [SRCLAT-1:0]       r_vld_pipe;
  logic [SRCLAT-1:0][7:0]  r_idx_pipe;

  logic w_rise, w_fall, w_wr, w_issue, w_last;

  assign w_rise  = io_bus.vblk & ~r_vblk_d;
  assign w_fall  = ~io_bus.vblk & r_vblk_d;
  assign w_wr    = r_vld_pipe[SRCLAT-1];
  assign w_issue = (r_state == S_XFER) & ~w_fall & io_bus.bgnt & (r_icnt < NB_C);
  assign w_last  = w_wr & (r_wcnt == LAST_C);

  always_ff @(posedge i_vclk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state    <= S_IDLE;
      r_pend     <= 1'b0;
      r_vblk_d   <= 1'b0;
      r_sprb     <= 1'b0;
      r_breq     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sawe     <= 1'b0;
      r_base     <= '0;
      r_srcad    <= '0;
      r_icnt     <= '0;
      r_wcnt     <= '0;
      r_saad     <= '0;
      r_sawd     <= '0;
      r_vld_pipe <= '0;
      r_idx_pipe <= '0;
    end else begin
      r_vblk_d <= io_bus.vblk;
      // A START landing in the DONE cycle re-arms the request.
      r_pend   <= io_bus.start | (r_pend & (r_state != S_FLIP));
      r_done   <= 1'b0;

      for (int k = SRCLAT - 1; k > 0; k--) begin
        r_vld_pipe[k] <= r_vld_pipe[k-1];
        r_idx_pipe[k] <= r_idx_pipe[k-1];
      end
      r_vld_pipe[0] <= w_issue;
      r_idx_pipe[0] <= r_icnt[7:0];

      // In-flight reads always retire, even through an abort.
      r_sawe <= w_wr;
      if (w_wr) begin
        r_saad <= {~r_sprb, r_idx_pipe[SRCLAT-1]};
        r_sawd <= io_bus.srcrd;
        r_wcnt <= r_wcnt + 9'd1;
      end

      if (w_issue) begin
        r_srcad <= r_base + {7'd0, r_icnt};
        r_icnt  <= r_icnt + 9'd1;
      end

      case (r_state)
        S_IDLE: if (w_rise && r_pend) begin
          r_state <= S_REQ;
          r_base  <= io_bus.srcbase;
          r_icnt  <= '0;
          r_wcnt  <= '0;
          r_breq  <= 1'b1;
          r_busy  <= 1'b1;
        end
        S_REQ, S_XFER: begin
          if (w_fall) begin
            r_state <= S_IDLE;
            r_breq  <= 1'b0;
            r_busy  <= 1'b0;
            r_icnt  <= '0;
            r_wcnt  <= '0;
          end else if (r_state == S_REQ) begin
            if (io_bus.bgnt) r_state <= S_XFER;
          end else if (w_last) begin
            r_state <= S_FLIP;
            r_sprb  <= ~r_sprb;
            r_done  <= 1'b1;
            r_breq  <= 1'b0;
          end
        end
        S_FLIP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.breq  = r_breq;
  assign io_bus.srcad = r_srcad;
  assign io_bus.sawe  = r_sawe;
  assign io_bus.saad  = r_saad;
  assign io_bus.sawd  = r_sawd;
  assign io_bus.sprb  = r_sprb;
  assign io_bus.busy  = r_busy;
  assign io_bus.done  = r_done;

endmodule

// File: tb/tb_sprite_dma.sv
// Bench for sprite_dma: byte-index reference model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_sprite_dma;
  localparam int SPR = 48;
  localparam int N   = 4 * SPR;

  logic gclk    = 1'b0;
  logic grst_n  = 1'b0;
  always #5 gclk = ~gclk;

  sprite_dma_if bus();
  sprite_dma #(.SPRITES(SPR), .SRCLAT(1)) dut (
    .i_vclk  (gclk),
    .i_resetn(grst_n),
    .io_bus  (bus)
  );

  function automatic logic [7:0] memf(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
  endfunction
  assign bus.srcrd = memf(bus.srcad);

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (phases: 0 idle, 1 waiting grant, 2 copying, 3 flip)
  int          m_phase = 0, m_next = 0, m_written = 0, m_infl = -1;
  bit          m_pend = 0, m_pv = 0, m_bank = 0;
  logic [15:0] m_base = '0;
  bit          e_breq = 0, e_busy = 0, e_done = 0, e_sawe = 0, e_iss = 0;
  logic [8:0]  e_saad = '0;
  logic [7:0]  e_sawd = '0;
  logic [15:0] e_srcad = '0;

  task automatic model_step();
    int ph = m_phase, nxt = m_next, wr = m_written, infl = m_infl, ninfl = -1;
    bit bank = m_bank, rose, fell, npend, w = 0, dn = 0, iss = 0;
    logic [15:0] base = m_base, sa = e_srcad;
    logic [8:0]  wa = e_saad;
    logic [7:0]  wd = e_sawd;
    rose  = bus.vblk && !m_pv;
    fell  = !bus.vblk && m_pv;
    npend = bus.start || (m_pend && ph != 3);
    if (infl >= 0) begin
      w  = 1;
      wa = {~bank, 8'(infl)};
      wd = memf(base + 16'(infl));
      wr++;
    end
    case (ph)
      0: if (rose && m_pend) begin ph = 1; base = bus.srcbase; nxt = 0; wr = 0; end
      1: if (fell) ph = 0; else if (bus.bgnt) ph = 2;
      2: if (fell) begin ph = 0; nxt = 0; wr = 0; end
         else if (w && wr == N) begin ph = 3; bank = !bank; dn = 1; end
         else if (bus.bgnt && nxt < N) begin iss = 1; sa = base + 16'(nxt); ninfl = nxt; nxt++; end
      default: ph = 0;
    endcase
    m_phase <= ph;   m_next <= nxt;  m_written <= wr; m_infl <= ninfl;
    m_pend  <= npend; m_pv  <= bus.vblk; m_bank <= bank; m_base <= base;
    e_breq  <= (ph == 1 || ph == 2);
    e_busy  <= (ph != 0);
    e_done  <= dn;  e_sawe <= w;  e_saad <= wa;  e_sawd <= wd;
    e_iss   <= iss; e_srcad <= sa;
  endtask

  always @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      m_phase <= 0; m_next <= 0; m_written <= 0; m_infl <= -1;
      m_pend <= 0; m_pv <= 0; m_bank <= 0; m_base <= '0;
      e_breq <= 0; e_busy <= 0; e_done <= 0; e_sawe <= 0; e_iss <= 0;
    end else begin
      model_step();
    end
  end

  bit chk_en = 0;
  always @(negedge gclk) begin
    if (grst_n && chk_en) begin
      chk("breq", bus.breq, e_breq);
      chk("busy", bus.busy, e_busy);
      chk("done", bus.done, e_done);
      chk("sprb", bus.sprb, m_bank);
      chk("sawe", bus.sawe, e_sawe);
      if (e_sawe) begin
        chk("saad", bus.saad, e_saad);
        chk("sawd", bus.sawd, e_sawd);
      end
      if (e_iss) chk("srcad", bus.srcad, e_srcad);
    end
  end

  // ---------------- monotonic observation counters
  int          wr_cnt = 0, done_cnt = 0;
  logic [8:0]  first_saad = '0, last_saad = '0;
  logic [7:0]  first_data = '0;
  logic [15:0] prev_srcad = '0;
  bit          wrap_seen = 0;
  always @(negedge gclk) begin
    if (grst_n) begin
      if (bus.sawe) begin
        wr_cnt <= wr_cnt + 1;
        if (bus.saad[7:0] == 8'd0) begin first_saad <= bus.saad; first_data <= bus.sawd; end
        if (bus.saad[7:0] == 8'(N - 1)) last_saad <= bus.saad;
      end
      if (bus.done) done_cnt <= done_cnt + 1;
      if (prev_srcad == 16'hFFFF && bus.srcad == 16'h0000) wrap_seen <= 1;
      prev_srcad <= bus.srcad;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge gclk);
    #1;
  endtask

  task automatic pulse_start(input logic [15:0] base);
    bus.srcbase = base;
    bus.start   = 1'b1;
    tick(1);
    bus.start   = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int c = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && c < budget) begin tick(1); c++; end
    if (done_cnt == d0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: got no DONE expected DONE within %0d cycles", nm, budget);
    end
  endtask

  task automatic wait_writes(input string nm, input int w0, input int target, input int budget);
    int c = 0;
    while (wr_cnt - w0 < target && c < budget) begin tick(1); c++; end
    if (wr_cnt - w0 < target) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: got %0d writes expected %0d", nm, wr_cnt - w0, target);
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_breq"},  bus.breq,  0);
    chk({nm, "_busy"},  bus.busy,  0);
    chk({nm, "_done"},  bus.done,  0);
    chk({nm, "_sprb"},  bus.sprb,  0);
    chk({nm, "_sawe"},  bus.sawe,  0);
    chk({nm, "_srcad"}, bus.srcad, 0);
    chk({nm, "_saad"},  bus.saad,  0);
    chk({nm, "_sawd"},  bus.sawd,  0);
  endtask

  initial begin
    int w0, d0, c;
    bit seen;
    bus.vblk = 0; bus.start = 0; bus.srcbase = '0; bus.bgnt = 0;
    tick(3);
    chk_reset_outputs("rst");
    grst_n = 1; chk_en = 1;
    tick(2);

    // Full copy, grant held
    bus.bgnt = 1;
    pulse_start(16'h9000);
    tick(2);
    w0 = wr_cnt; d0 = done_cnt;
    bus.vblk = 1;
    wait_done("t1_done", 600);
    tick(3);
    chk("t1_writes", wr_cnt - w0, 192);
    chk("t1_first_saad", first_saad, 9'h100);
    chk("t1_first_data", first_data, 8'h53);
    chk("t1_last_saad", last_saad, 9'h1BF);
    chk("t1_sprb", bus.sprb, 1);
    chk("t1_dones", done_cnt - d0, 1);
    bus.vblk = 0; tick(2);

    // Grant toggling 1,0,0,1
    pulse_start(16'h1234);
    w0 = wr_cnt; d0 = done_cnt;
    bus.vblk = 1;
    c = 0;
    while (done_cnt == d0 && c < 3000) begin
      bus.bgnt = (c % 4 == 0) || (c % 4 == 3);
      tick(1); c++;
    end
    if (done_cnt == d0) begin n_cmp++; n_fail++; $display("FAIL t2_done: got no DONE expected DONE"); end
    bus.bgnt = 1; tick(3);
    chk("t2_writes", wr_cnt - w0, 192);
    chk("t2_first_saad", first_saad, 9'h000);
    chk("t2_last_saad", last_saad, 9'h0BF);
    chk("t2_sprb", bus.sprb, 0);
    chk("t2_dones", done_cnt - d0, 1);
    bus.vblk = 0; tick(2);

    // Abort on VBLK fall after ~50 writes, then restart
    pulse_start(16'h4000);
    w0 = wr_cnt; d0 = done_cnt;
    bus.vblk = 1;
    wait_writes("t3_reach50", w0, 50, 400);
    bus.vblk = 0;
    tick(4);
    chk("t3_dones", done_cnt - d0, 0);
    chk("t3_sprb", bus.sprb, 0);
    chk("t3_breq", bus.breq, 0);
    chk("t3_busy", bus.busy, 0);
    w0 = wr_cnt;
    bus.vblk = 1;
    wait_done("t3_restart", 600);
    tick(3);
    chk("t3_writes", wr_cnt - w0, 192);
    chk("t3_first_saad", first_saad, 9'h100);
    chk("t3_first_data", first_data, 8'h5E);
    chk("t3_sprb2", bus.sprb, 1);
    bus.vblk = 0; tick(2);

    // Reset, VBLK with no request, then START in the DONE cycle
    grst_n = 0; tick(2); grst_n = 1; tick(1);
    bus.vblk = 1; tick(6);
    chk("t4_idle_breq", bus.breq, 0);
    chk("t4_idle_busy", bus.busy, 0);
    bus.vblk = 0; tick(2);
    pulse_start(16'h2000);
    d0 = done_cnt;
    bus.vblk = 1;
    c = 0; seen = 0;
    while (!seen && c < 600) begin
      tick(1); c++;
      if (bus.done) seen = 1;
    end
    if (!seen) begin n_cmp++; n_fail++; $display("FAIL t4_done1: got no DONE expected DONE"); end
    bus.start = 1; tick(1); bus.start = 0;
    bus.vblk = 0; tick(2);
    bus.vblk = 1;
    wait_done("t4_done2", 600);
    tick(3);
    chk("t4_dones", done_cnt - d0, 2);
    chk("t4_sprb", bus.sprb, 0);
    bus.vblk = 0; tick(2);

    // Address wrap, then reset mid-transfer
    pulse_start(16'hFFF0);
    w0 = wr_cnt;
    bus.vblk = 1;
    wait_writes("t5_reach100", w0, 100, 400);
    chk("t5_wrap", wrap_seen, 1);
    #2 grst_n = 0;
    #1 chk_reset_outputs("t5_rst");
    @(posedge gclk); #1 grst_n = 1;
    w0 = wr_cnt;
    bus.vblk = 0; tick(3);
    bus.vblk = 1; tick(10);
    bus.vblk = 0; tick(3);
    bus.vblk = 1; tick(20);
    chk("t5_no_writes", wr_cnt - w0, 0);
    chk("t5_breq", bus.breq, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
